cpu_run_controller: RTL and testbench
=====================================

# cpu_run_controller

Synthesizable run controller for the multi-cycle CPU, generalising the fixed reset-then-free-run bench stimulus into a parametrised sequencer. It holds the CPU in reset for a programmable number of cycles, releases it on `start`, counts cycles and retired fetches, and ends the run on self-loop halt detection or a watchdog timeout. It sits between board/bench control and `MultiCycleCPU`, driving the CPU's reset and observing its PC.

## Interface

Parameters:
- `PC_W`, 32: width of the observed PC.
- `CNT_W`, 32: width of both counters.
- `RESET_CYCLES`, 2: cycles `cpu_reset` is held after `start`; legal range ≥1.
- `HALT_REPEATS`, 4: consecutive repeated fetches at one PC that declare halt; legal range ≥1.
- `TIMEOUT`, 100000: RUN-state cycle limit; legal range ≥1 and < 2^CNT_W.

Ports:
- `clk` in 1: single clock; all state is updated on the rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `start` in 1: request a run; sampled every cycle.
- `pc_valid` in 1: single-cycle strobe; asserted once per instruction fetch.
- `pc` in PC_W: fetch address, qualified by `pc_valid`.
- `cpu_reset` out 1: reset to the CPU, active-high.
- `running` out 1: high in RUN.
- `done` out 1: high in HALT.
- `timeout` out 1: high in TMO.
- `cycle_count` out CNT_W: cycles spent in RUN.
- `instr_count` out CNT_W: `pc_valid` strobes seen in RUN.

## Operation

- Reset values: state IDLE, `cpu_reset`=1, `running`/`done`/`timeout`=0, both counts 0, last_pc 0, repeat count 0.
- FSM states are IDLE, RST, RUN, HALT, TMO.
- IDLE: `cpu_reset`=1. On `start`, go to RST, clear both counters, clear repeat count, and load the reset down-counter with RESET_CYCLES-1.
- RST: `cpu_reset`=1 and the down-counter decrements. On the cycle it reads 0, go to RUN. `start` is ignored in RST.
- RUN:
  - `cpu_reset`=0 and `cycle_count` increments every cycle.
  - `instr_count` increments on each `pc_valid`.
  - Both counters saturate at all-ones.
  - On `pc_valid`: if `pc`==last_pc, the repeat count increments; otherwise the repeat count clears and last_pc←`pc`.
  - The first fetch after RST always loads last_pc, so a first `pc` of 0 never counts as a repeat.
- Halt: a `pc_valid` in RUN that makes the repeat count equal HALT_REPEATS moves the FSM to HALT.
- Timeout: `cycle_count` equal to TIMEOUT-1 in RUN moves the FSM to TMO.
- If halt and timeout occur in the same cycle, HALT wins.
- HALT / TMO:
  - `cpu_reset`=1, freezing the CPU.
  - Counters and the status flag hold.
  - `start` re-enters RST and clears the counters and flags.
- `start` in RUN is ignored. There is no abort input; only `reset` aborts.
- `reset` mid-run returns to reset values immediately (asynchronously), with `cpu_reset`=1.

## Timing

- `start` sampled high at edge N (from IDLE): RST is occupied during cycles N+1 … N+RESET_CYCLES, and RUN begins at edge N+RESET_CYCLES.
- `cpu_reset` is registered and falls at edge N+RESET_CYCLES.
- Counters are registered. `cycle_count` reads 1 after the first RUN cycle.
- The triggering `pc_valid` and the HALT transition occur on the same edge. The final strobe is counted in `instr_count`.
- In TMO, `cycle_count` holds TIMEOUT.
- All outputs are registered, with no combinational path from inputs to outputs.

## Structure

- Package `cpu_test_pkg`: holds the state enum (IDLE, RST, RUN, HALT, TMO) and the default parameter constants.
- Sub-module `pc_halt_detector`: holds last_pc and the repeat count, with inputs `clk`, `reset`, `clear`, `pc_valid`, `pc` and a one-cycle `halt` output. Parameters are PC_W and HALT_REPEATS.
- The top level holds the FSM, the reset down-counter and the two counters.

## Test plan

- Reset: assert `reset` mid-cycle → outputs go to reset values immediately without waiting for an edge; `cpu_reset`=1.
- Reset sequence: RESET_CYCLES=3, pulse `start` at edge 10 → `cpu_reset` low from edge 13; `running` high from edge 13.
- Halt: strobe PCs 0x0, 0x4, 0x8, then 0x8 four times (HALT_REPEATS=4) → HALT on the 4th repeat; `instr_count`=7; `done`=1; `cpu_reset`=1.
- Non-halt repeats: PCs 0x8 ×3, 0xC, 0x8 ×3 → no HALT, because the repeat count clears on 0xC.
- Timeout: TIMEOUT=50, no repeats → TMO after 50 RUN cycles; `cycle_count`=50; `timeout`=1.
- Halt and timeout together: TIMEOUT=20, 4th repeat lands on RUN cycle 20 → HALT, not TMO. Then `start` → RST, counters read 0.

Source files
------------

// File: rtl/cpu_test_pkg.sv
// cpu_test_pkg: shared state encoding and default parameters for the CPU run controller
package cpu_test_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RST,
    RUN,
    HALT,
    TMO
  } state_e;

  localparam int DEF_PC_W         = 32;
  localparam int DEF_CNT_W        = 32;
  localparam int DEF_RESET_CYCLES = 2;
  localparam int DEF_HALT_REPEATS = 4;
  localparam int DEF_TIMEOUT      = 100000;

endpackage

// File: rtl/pc_halt_detector.sv
// pc_halt_detector: flags a self-loop once the same fetch PC repeats HALT_REPEATS times in a row
module pc_halt_detector
  import cpu_test_pkg::*;
#(
  parameter int PC_W         = DEF_PC_W,
  parameter int HALT_REPEATS = DEF_HALT_REPEATS
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clear,
  input  logic            pc_valid,
  input  logic [PC_W-1:0] pc,
  output logic            halt
);

  localparam int REP_W = $clog2(HALT_REPEATS + 1);

  logic [PC_W-1:0]  last_pc_q;
  logic [REP_W-1:0] rep_q;
  logic             first_q;
  logic             hit;

  // The first fetch after a clear only loads last_pc, so a stale PC can never count as a repeat
  assign hit  = pc_valid && !first_q && pc == last_pc_q;
  assign halt = hit && rep_q == REP_W'(HALT_REPEATS - 1);

  // Track the current PC and how many consecutive times it has been fetched again
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_pc_q <= '0;
      rep_q     <= '0;
      first_q   <= 1'b1;
    end else if (clear) begin
      rep_q     <= '0;
      first_q   <= 1'b1;
    end else if (pc_valid) begin
      rep_q     <= hit ? rep_q + REP_W'(1) : '0;
      last_pc_q <= pc;
      first_q   <= 1'b0;
    end
  end

endmodule

// File: rtl/cpu_run_controller.sv
// cpu_run_controller: holds the CPU in reset, releases it on start, counts the run and ends it on halt or timeout
module cpu_run_controller
  import cpu_test_pkg::*;
#(
  parameter int PC_W         = DEF_PC_W,
  parameter int CNT_W        = DEF_CNT_W,
  parameter int RESET_CYCLES = DEF_RESET_CYCLES,
  parameter int HALT_REPEATS = DEF_HALT_REPEATS,
  parameter int TIMEOUT      = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             pc_valid,
  input  logic [PC_W-1:0]  pc,
  output logic             cpu_reset,
  output logic             running,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instr_count
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] rcnt_q, rcnt_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [CNT_W-1:0] ins_q, ins_d;
  logic             cpu_reset_q, running_q, done_q, timeout_q;
  logic             fetch, clear, halt;

  // Only fetches during RUN are observed; start is honoured only from the resting states
  assign fetch = pc_valid && state_q == RUN;
  assign clear = start && (state_q == IDLE || state_q == HALT || state_q == TMO);

  pc_halt_detector #(
    .PC_W        (PC_W),
    .HALT_REPEATS(HALT_REPEATS)
  ) u_halt (
    .clk     (clk),
    .reset   (reset),
    .clear   (clear),
    .pc_valid(fetch),
    .pc      (pc),
    .halt    (halt)
  );

  // Next-state logic: sequencing, reset down-counter and saturating run counters
  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    cyc_d   = cyc_q;
    ins_d   = ins_q;
    case (state_q)
      IDLE, HALT, TMO: begin
        if (start) begin
          state_d = RST;
          rcnt_d  = CNT_W'(RESET_CYCLES - 1);
          cyc_d   = '0;
          ins_d   = '0;
        end
      end
      RST: begin
        if (rcnt_q == '0) state_d = RUN;
        else rcnt_d = rcnt_q - CNT_W'(1);
      end
      RUN: begin
        cyc_d = cyc_q + CNT_W'(~&cyc_q);
        ins_d = fetch ? ins_q + CNT_W'(~&ins_q) : ins_q;
        if (halt) state_d = HALT;
        else if (cyc_q == CNT_W'(TIMEOUT - 1)) state_d = TMO;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counters and status flags; flags decode the next state so outputs stay registered
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      rcnt_q      <= '0;
      cyc_q       <= '0;
      ins_q       <= '0;
      cpu_reset_q <= 1'b1;
      running_q   <= 1'b0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rcnt_q      <= rcnt_d;
      cyc_q       <= cyc_d;
      ins_q       <= ins_d;
      cpu_reset_q <= state_d != RUN;
      running_q   <= state_d == RUN;
      done_q      <= state_d == HALT;
      timeout_q   <= state_d == TMO;
    end
  end

  assign cpu_reset   = cpu_reset_q;
  assign running     = running_q;
  assign done        = done_q;
  assign timeout     = timeout_q;
  assign cycle_count = cyc_q;
  assign instr_count = ins_q;

endmodule

// File: tb/tb_cpu_run_controller.sv
// tb_cpu_run_controller: directed vector table plus hand-written halt, timeout and reset sequences
module tb_cpu_run_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, pc_valid;
  logic [31:0] pc;
  logic        cpu_reset, running, done, timeout;
  logic [31:0] cycle_count, instr_count;
  logic        start2, pv2;
  logic [31:0] pc2;
  logic        cpu_reset2, running2, done2, timeout2;
  logic [31:0] cycle_count2, instr_count2;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        st, pv;
    logic [31:0] pc;
    logic        cr, run, dn, to;
    logic [31:0] cyc, ins;
  } vec_t;

  vec_t tbl[$];

  always #5 clk = ~clk;

  cpu_run_controller #(
    .PC_W(32), .CNT_W(32), .RESET_CYCLES(3), .HALT_REPEATS(4), .TIMEOUT(50)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .pc_valid(pc_valid), .pc(pc),
    .cpu_reset(cpu_reset), .running(running), .done(done), .timeout(timeout),
    .cycle_count(cycle_count), .instr_count(instr_count)
  );

  cpu_run_controller #(
    .PC_W(32), .CNT_W(32), .RESET_CYCLES(3), .HALT_REPEATS(4), .TIMEOUT(20)
  ) dut20 (
    .clk(clk), .reset(reset), .start(start2), .pc_valid(pv2), .pc(pc2),
    .cpu_reset(cpu_reset2), .running(running2), .done(done2), .timeout(timeout2),
    .cycle_count(cycle_count2), .instr_count(instr_count2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic st, input logic pv, input logic [31:0] p,
                     input logic cr, input logic run, input logic dn, input logic to,
                     input logic [31:0] cyc, input logic [31:0] ins);
    vec_t v;
    v.st = st; v.pv = pv; v.pc = p; v.cr = cr; v.run = run; v.dn = dn; v.to = to;
    v.cyc = cyc; v.ins = ins;
    tbl.push_back(v);
  endtask

  task automatic chk_all(input string tag, input logic cr, input logic run, input logic dn,
                         input logic to, input logic [31:0] cyc, input logic [31:0] ins);
    chk({tag, ".cpu_reset"}, 32'(cpu_reset), 32'(cr));
    chk({tag, ".running"}, 32'(running), 32'(run));
    chk({tag, ".done"}, 32'(done), 32'(dn));
    chk({tag, ".timeout"}, 32'(timeout), 32'(to));
    chk({tag, ".cycle_count"}, cycle_count, cyc);
    chk({tag, ".instr_count"}, instr_count, ins);
  endtask

  initial begin
    int run_cycles;
    reset = 1'b1; start = 1'b0; pc_valid = 1'b0; pc = '0;
    start2 = 1'b0; pv2 = 1'b0; pc2 = '0;
    repeat (2) tick();
    chk_all("rst", 1, 0, 0, 0, 0, 0);
    reset = 1'b0;
    tick();
    chk_all("idle", 1, 0, 0, 0, 0, 0);

    // reset sequence, halt on fourth repeat, start ignored in RST/RUN/HALT
    add(1, 0, 32'h0, 1, 0, 0, 0, 0, 0);
    add(1, 0, 32'h0, 1, 0, 0, 0, 0, 0);
    add(0, 0, 32'h0, 1, 0, 0, 0, 0, 0);
    add(0, 0, 32'h0, 0, 1, 0, 0, 0, 0);
    add(0, 1, 32'h0, 0, 1, 0, 0, 1, 1);
    add(0, 1, 32'h4, 0, 1, 0, 0, 2, 2);
    add(0, 1, 32'h8, 0, 1, 0, 0, 3, 3);
    add(0, 1, 32'h8, 0, 1, 0, 0, 4, 4);
    add(1, 0, 32'h8, 0, 1, 0, 0, 5, 4);
    add(0, 1, 32'h8, 0, 1, 0, 0, 6, 5);
    add(0, 1, 32'h8, 0, 1, 0, 0, 7, 6);
    add(0, 1, 32'h8, 1, 0, 1, 0, 8, 7);
    add(0, 0, 32'h0, 1, 0, 1, 0, 8, 7);
    add(0, 1, 32'h8, 1, 0, 1, 0, 8, 7);
    // restart from HALT; first fetch of 0x8 must only load, 0xC clears the repeat run
    add(1, 0, 32'h0, 1, 0, 0, 0, 0, 0);
    add(1, 0, 32'h0, 1, 0, 0, 0, 0, 0);
    add(0, 0, 32'h0, 1, 0, 0, 0, 0, 0);
    add(0, 0, 32'h0, 0, 1, 0, 0, 0, 0);
    add(0, 1, 32'h8, 0, 1, 0, 0, 1, 1);
    add(0, 1, 32'h8, 0, 1, 0, 0, 2, 2);
    add(0, 1, 32'h8, 0, 1, 0, 0, 3, 3);
    add(0, 1, 32'h8, 0, 1, 0, 0, 4, 4);
    add(0, 1, 32'hC, 0, 1, 0, 0, 5, 5);
    add(0, 1, 32'h8, 0, 1, 0, 0, 6, 6);
    add(0, 1, 32'h8, 0, 1, 0, 0, 7, 7);
    add(0, 1, 32'h8, 0, 1, 0, 0, 8, 8);
    add(0, 1, 32'h8, 0, 1, 0, 0, 9, 9);
    add(0, 1, 32'h8, 1, 0, 1, 0, 10, 10);

    for (int i = 0; i < tbl.size(); i++) begin
      start = tbl[i].st; pc_valid = tbl[i].pv; pc = tbl[i].pc;
      tick();
      chk_all($sformatf("vec%0d", i), tbl[i].cr, tbl[i].run, tbl[i].dn, tbl[i].to,
              tbl[i].cyc, tbl[i].ins);
    end
    start = 1'b0; pc_valid = 1'b0;

    // timeout: 50 RUN cycles with no fetches
    start = 1'b1;
    tick();
    start = 1'b0;
    run_cycles = 0;
    for (int i = 0; i < 200 && !timeout; i++) begin
      tick();
      if (running) run_cycles++;
    end
    chk("tmo.run_cycles", 32'(run_cycles), 32'd50);
    chk_all("tmo", 1, 0, 0, 1, 50, 0);
    pc_valid = 1'b1; pc = 32'h40;
    repeat (2) tick();
    pc_valid = 1'b0;
    chk_all("tmo_hold", 1, 0, 0, 1, 50, 0);

    // asynchronous reset in the middle of a run
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (8) tick();
    chk("mid.running", 32'(running), 32'd1);
    #3 reset = 1'b1;
    #1 chk_all("async_rst", 1, 0, 0, 0, 0, 0);
    #2 reset = 1'b0;
    tick();
    chk_all("post_rst", 1, 0, 0, 0, 0, 0);

    // halt and timeout on the same edge: HALT wins
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    repeat (3) tick();
    chk("both.running0", 32'(running2), 32'd1);
    for (int k = 1; k <= 20; k++) begin
      pv2 = k >= 16; pc2 = 32'h10;
      tick();
      if (k == 19) chk("both.running19", 32'(running2), 32'd1);
    end
    pv2 = 1'b0;
    chk("both.done", 32'(done2), 32'd1);
    chk("both.timeout", 32'(timeout2), 32'd0);
    chk("both.cpu_reset", 32'(cpu_reset2), 32'd1);
    chk("both.cycle_count", cycle_count2, 32'd20);
    chk("both.instr_count", instr_count2, 32'd5);
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    chk("restart.done", 32'(done2), 32'd0);
    chk("restart.running", 32'(running2), 32'd0);
    chk("restart.cpu_reset", 32'(cpu_reset2), 32'd1);
    chk("restart.cycle_count", cycle_count2, 32'd0);
    chk("restart.instr_count", instr_count2, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
